// File: rtl/muldiv_issue.sv
// muldiv_issue -- issue/hold controller in front of the multicycle mul/div unit.
//
// Accepts one mul/div op from the execute stage and holds its operands on the
// multicycle unit while it runs. It captures the result on mc_ok and presents
// it downstream with a valid/ready handshake. While an op is outstanding it
// stalls the pipeline, and it forwards flush/reset to the unit.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               pipeline flush (any state -> IDLE, result discarded)
//   in_valid/in_ready   op handshake from execute; in_a, in_b, in_type operands
//   mc_valid, mc_a, mc_b, mc_type, mc_flush   drive to multicycle unit
//   mc_c, mc_ok         result / completion from multicycle unit
//   out_valid/out_ready result handshake; out_data result
//   stall               pipeline hold request
//
// Optional feature: define MULDIV_DIV0_FAST_EN to complete divide-by-zero ops
// directly (IDLE -> DONE) without launching the multicycle unit.

package muldiv_issue_pkg;
    typedef enum logic [3:0] {
        MULT_MUL, MULT_MULH, MULT_MULHU, MULT_MULHSU, MULT_MULW,
        MULT_DIV, MULT_DIVU, MULT_DIVW, MULT_DIVUW,
        MULT_REM, MULT_REMU, MULT_REMW, MULT_REMUW
    } mult_t;
endpackage

module muldiv_issue
    import muldiv_issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  mult_t       in_type,
    output logic        mc_valid,
    output logic [63:0] mc_a,
    output logic [63:0] mc_b,
    output mult_t       mc_type,
    output logic        mc_flush,
    input  logic [63:0] mc_c,
    input  logic        mc_ok,
    output logic        out_valid,
    output logic [63:0] out_data,
    input  logic        out_ready,
    output logic        stall
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q;
    logic [63:0] op_a_q;
    logic [63:0] op_b_q;
    mult_t       op_type_q;
    logic [63:0] res_q;
    logic        accept;
    logic        div0_fast;
    logic [63:0] div0_res;

    // Flush and reset both block acceptance in the same cycle.
    assign in_ready  = (state_q == IDLE) & ~reset & ~flush;
    assign accept    = in_valid & in_ready;
    assign stall     = (state_q != IDLE) | accept;

    assign mc_valid  = (state_q == BUSY);
    assign mc_a      = op_a_q;
    assign mc_b      = op_b_q;
    assign mc_type   = op_type_q;
    assign mc_flush  = flush | reset;

    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;

`ifdef MULDIV_DIV0_FAST_EN
    // Divide-by-zero results follow the RISC-V convention: quotient all ones,
    // remainder equals the dividend (W forms sign-extend the low word).
    always_comb begin
        div0_fast = 1'b0;
        div0_res  = '1;
        case (in_type)
            MULT_DIV, MULT_DIVU: begin
                div0_fast = (in_b == '0);
            end
            MULT_DIVW, MULT_DIVUW: begin
                div0_fast = (in_b[31:0] == '0);
            end
            MULT_REM, MULT_REMU: begin
                div0_fast = (in_b == '0);
                div0_res  = in_a;
            end
            MULT_REMW, MULT_REMUW: begin
                div0_fast = (in_b[31:0] == '0);
                div0_res  = {{32{in_a[31]}}, in_a[31:0]};
            end
            default: ;
        endcase
    end
`else
    assign div0_fast = 1'b0;
    assign div0_res  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_type_q <= MULT_MUL;
            res_q     <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q    <= in_a;
                        op_b_q    <= in_b;
                        op_type_q <= in_type;
                        if (div0_fast) begin
                            res_q   <= div0_res;
                            state_q <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mc_ok) begin
                        res_q   <= mc_c;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_issue.sv
// Testbench for muldiv_issue: directed ops against a hand-driven multicycle
// stub; expected results go into a scoreboard queue, and a monitor compares
// them whenever a result is handed off downstream.

module tb_muldiv_issue;
    import muldiv_issue_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [63:0] in_a, in_b;
    mult_t       in_type;
    logic        mc_valid, mc_flush, mc_ok;
    logic [63:0] mc_a, mc_b, mc_c;
    mult_t       mc_type;
    logic        out_valid, out_ready, stall;
    logic [63:0] out_data;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    muldiv_issue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_type(in_type),
        .mc_valid(mc_valid), .mc_a(mc_a), .mc_b(mc_b), .mc_type(mc_type),
        .mc_flush(mc_flush), .mc_c(mc_c), .mc_ok(mc_ok),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall(stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a result is consumed when out_valid & out_ready.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h required=none", out_data);
            end else begin
                chk("sb_out_data", out_data, sb.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_mc_valid",  mc_valid,  1'b0);
        chk("rst_mc_a",      mc_a,      64'd0);
        chk("rst_mc_b",      mc_b,      64'd0);
        chk("rst_mc_type",   mc_type,   MULT_MUL);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  64'd0);
        chk("rst_stall",     stall,     1'b0);
        chk("rst_mc_flush",  mc_flush,  1'b0);
    endtask

    // Full op: accept at T, stub raises mc_ok in BUSY cycle k (cycle T+k),
    // out_ready held low for 'hold' DONE cycles before the handoff.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input mult_t t,
                         input int k, input logic [63:0] c, input int hold);
        in_valid = 1'b1; in_a = a; in_b = b; in_type = t;
        @(negedge clk);
        chk("acc_in_ready", in_ready, 1'b1);
        chk("acc_stall", stall, 1'b1);
        sb.push_back(c);
        next_cycle();
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_type = MULT_MULH;
        for (int i = 1; i <= k; i++) begin
            mc_ok = (i == k);
            mc_c  = (i == k) ? c : ~c;
            @(negedge clk);
            chk("busy_mc_valid", mc_valid, 1'b1);
            chk("busy_mc_a", mc_a, a);
            chk("busy_mc_b", mc_b, b);
            chk("busy_mc_type", mc_type, t);
            chk("busy_stall", stall, 1'b1);
            chk("busy_in_ready", in_ready, 1'b0);
            chk("busy_out_valid", out_valid, 1'b0);
            next_cycle();
        end
        mc_ok = 1'b0; mc_c = 64'hDEAD_BEEF_0BAD_F00D;
        for (int h = 0; h <= hold; h++) begin
            out_ready = (h == hold);
            @(negedge clk);
            chk("done_out_valid", out_valid, 1'b1);
            chk("done_out_data", out_data, c);
            chk("done_mc_valid", mc_valid, 1'b0);
            chk("done_in_ready", in_ready, 1'b0);
            chk("done_stall", stall, 1'b1);
            next_cycle();
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_out_valid", out_valid, 1'b0);
        chk("post_in_ready", in_ready, 1'b1);
        chk("post_stall", stall, 1'b0);
        chk("post_mc_a_hold", mc_a, a);
        next_cycle();
    endtask

`ifdef MULDIV_DIV0_FAST_EN
    task automatic fast_op(input logic [63:0] a, input logic [63:0] b, input mult_t t,
                           input logic [63:0] exp);
        in_valid = 1'b1; in_a = a; in_b = b; in_type = t;
        @(negedge clk);
        chk("f0_stall", stall, 1'b1);
        sb.push_back(exp);
        next_cycle();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("f0_out_valid", out_valid, 1'b1);
        chk("f0_out_data", out_data, exp);
        chk("f0_mc_valid", mc_valid, 1'b0);
        next_cycle();
        out_ready = 1'b0;
        @(negedge clk);
        chk("f0_idle", in_ready, 1'b1);
        chk("f0_mc_valid_after", mc_valid, 1'b0);
        next_cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_type = MULT_MUL; mc_c = '0; mc_ok = 1'b0; out_ready = 1'b0;
        next_cycle();
        in_valid = 1'b1;
        @(negedge clk);
        chk("in_reset_in_ready", in_ready, 1'b0);
        chk("in_reset_mc_flush", mc_flush, 1'b1);
        next_cycle();
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        next_cycle();

        // MUL 3*5: mc_ok in 3rd BUSY cycle -> out_valid at T+4.
        do_op(64'd3, 64'd5, MULT_MUL, 3, 64'd15, 0);

        // DIVW -7/2 with long latency and downstream backpressure.
        do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, MULT_DIVW, 66,
              64'hFFFF_FFFF_FFFF_FFFD, 5);

        // Flush in 2nd BUSY cycle of a DIV, coinciding with mc_ok.
        in_valid = 1'b1; in_a = 64'd100; in_b = 64'd7; in_type = MULT_DIV;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_busy1", mc_valid, 1'b1);
        next_cycle();
        flush = 1'b1; mc_ok = 1'b1; mc_c = 64'd55;
        @(negedge clk);
        chk("fl_mc_flush", mc_flush, 1'b1);
        chk("fl_busy2", mc_valid, 1'b1);
        next_cycle();
        flush = 1'b0; mc_ok = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_mc_valid", mc_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        chk("fl_stall", stall, 1'b0);
        next_cycle();
        mc_ok = 1'b1; mc_c = 64'd14;
        next_cycle();
        mc_ok = 1'b0;
        @(negedge clk);
        chk("fl_late_ok_ignored", out_valid, 1'b0);
        chk("fl_late_ok_out_data", out_data, 64'd0);
        next_cycle();

        // flush and in_valid together in IDLE: no accept.
        flush = 1'b1; in_valid = 1'b1; in_a = 64'd1; in_b = 64'd2; in_type = MULT_MULW;
        @(negedge clk);
        chk("fi_stall", stall, 1'b0);
        chk("fi_in_ready", in_ready, 1'b0);
        next_cycle();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fi_mc_valid", mc_valid, 1'b0);
        chk("fi_stall_after", stall, 1'b0);
        chk("fi_mc_a_unchanged", mc_a, 64'd100);
        next_cycle();

`ifdef MULDIV_DIV0_FAST_EN
        fast_op(64'h0000_0000_8000_0001, 64'h1_0000_0000, MULT_REMW,
                64'hFFFF_FFFF_8000_0001);
        fast_op(64'd42, 64'd0, MULT_DIVU, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        // Without the fast path a divide by zero launches normally.
        do_op(64'd42, 64'd0, MULT_DIVU, 2, 64'h0000_0000_1234_5678, 0);
`endif

        // Reset while in DONE: everything back to reset values.
        in_valid = 1'b1; in_a = 64'd9; in_b = 64'd9; in_type = MULT_MUL;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        mc_ok = 1'b1; mc_c = 64'd81;
        next_cycle();
        mc_ok = 1'b0;
        @(negedge clk);
        chk("rd_out_valid", out_valid, 1'b1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        next_cycle();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
